// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding and R/W bit values.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } i2c_state_t;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA oversampling front end: synchronisers, one history flop and
// edge / START / STOP event flags, all in the system clock domain.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl_now;
    logic                   sda_now;

    assign scl_now = scl_sync[SYNC_STAGES-1];
    assign sda_now = sda_sync[SYNC_STAGES-1];

    // Shift both lines through the synchroniser chain; reset to the idle (high) bus level so no edge fires on reset exit
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= (scl_sync << 1) | SYNC_STAGES'(scl_in);
            sda_sync <= (sda_sync << 1) | SYNC_STAGES'(sda_in);
            scl_hist <= scl_now;
            sda_hist <= sda_now;
        end
    end

    assign sda      = sda_now;
    assign scl_rise =  scl_now & ~scl_hist;
    assign scl_fall = ~scl_now &  scl_hist;
    assign start    =  scl_now &  scl_hist &  sda_hist & ~sda_now;
    assign stop     =  scl_now &  scl_hist & ~sda_hist &  sda_now;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with NREGS 8-bit registers behind an auto-incrementing pointer.
// Supports pointer-set, register write and register read sequences.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h2A,
    parameter int         NREGS       = 4,
    parameter int         SYNC_STAGES = 2,
    localparam int        PW          = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [8*NREGS-1:0] regs_q,
    output logic              wr_pulse,
    output logic [PW-1:0]     wr_idx,
    output logic              busy
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic       start;
    logic       stop;

    i2c_state_t state;
    logic [7:0] regs [NREGS];
    logic [PW-1:0] ptr;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [2:0] bit_cnt;
    logic       got_bit;
    logic       first_byte;
    logic       rw_bit;
    logic       rd_load;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    // Flatten the register file onto the regs_q output bus
    always_comb begin
        regs_q = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_q[8*i +: 8] = regs[i];
        end
    end

    // Protocol FSM: bits are sampled on SCL rise, SDA drive only changes after SCL fall
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            wr_pulse   <= 1'b0;
            wr_idx     <= '0;
            ptr        <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            bit_cnt    <= '0;
            got_bit    <= 1'b0;
            first_byte <= 1'b0;
            rw_bit     <= I2C_WRITE;
            rd_load    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_pulse <= 1'b0;
            if (stop) begin
                state  <= IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
            end else if (start) begin
                state   <= ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                got_bit <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            rx_shift <= {rx_shift[6:0], sda};
                            got_bit  <= 1'b1;
                        end else if (scl_fall && got_bit) begin
                            got_bit <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                if (rx_shift[7:1] == TARGET_ADDR) begin
                                    sda_oe <= 1'b1;
                                    busy   <= 1'b1;
                                    rw_bit <= rx_shift[0];
                                    state  <= ADDR_ACK;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            got_bit <= 1'b0;
                            if (rw_bit == I2C_READ) begin
                                tx_shift <= regs[ptr];
                                sda_oe   <= ~regs[ptr][7];
                                rd_load  <= 1'b0;
                                state    <= RD_BYTE;
                            end else begin
                                sda_oe     <= 1'b0;
                                first_byte <= 1'b1;
                                state      <= WR_BYTE;
                            end
                        end
                    end
                    WR_BYTE: begin
                        if (scl_rise) begin
                            rx_shift <= {rx_shift[6:0], sda};
                            got_bit  <= 1'b1;
                        end else if (scl_fall && got_bit) begin
                            got_bit <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                sda_oe  <= 1'b1;
                                state   <= WR_ACK;
                                if (first_byte) begin
                                    ptr        <= rx_shift[PW-1:0];
                                    first_byte <= 1'b0;
                                end else begin
                                    regs[ptr] <= rx_shift;
                                    wr_pulse  <= 1'b1;
                                    wr_idx    <= ptr;
                                    ptr       <= ptr + PTR_ONE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            got_bit <= 1'b0;
                            bit_cnt <= '0;
                            state   <= WR_BYTE;
                        end
                    end
                    RD_BYTE: begin
                        if (scl_fall) begin
                            if (rd_load) begin
                                tx_shift <= regs[ptr];
                                sda_oe   <= ~regs[ptr][7];
                                rd_load  <= 1'b0;
                                bit_cnt  <= '0;
                            end else if (bit_cnt == 3'd7) begin
                                sda_oe  <= 1'b0;
                                ptr     <= ptr + PTR_ONE;
                                bit_cnt <= '0;
                                state   <= RD_ACK;
                            end else begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                sda_oe   <= ~tx_shift[6];
                                bit_cnt  <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda) begin
                                rd_load <= 1'b1;
                                state   <= RD_BYTE;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: drives an I2C controller model on
// SCL/SDA and checks ACKs, read data, register contents and write strobes.
module tb_i2c_target_regs;

    logic        clk;
    logic        rst;
    logic        scl_drv;
    logic        sda_drv;
    logic        scl_in;
    logic        sda_in;
    logic        sda_oe;
    logic [31:0] regs_q;
    logic        wr_pulse;
    logic [1:0]  wr_idx;
    logic        busy;

    int tests_run;
    int tests_failed;
    int wr_total;
    int oe_cycles;
    int idx_log[$];

    logic       ack;
    logic [7:0] rdata;
    int         wr_base;
    int         oe_base;

    assign scl_in = scl_drv;
    assign sda_in = sda_drv & ~sda_oe;

    i2c_target_regs #(
        .TARGET_ADDR (7'h2A),
        .NREGS       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .regs_q   (regs_q),
        .wr_pulse (wr_pulse),
        .wr_idx   (wr_idx),
        .busy     (busy)
    );

    // Free-running system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Log write strobes and count cycles in which the target pulls SDA low
    always @(negedge clk) begin
        if (wr_pulse) begin
            wr_total++;
            idx_log.push_back(int'(wr_idx));
        end
        if (sda_oe) oe_cycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic d);
        scl_drv = s;
        sda_drv = d;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        applyStimulus(scl_drv, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic bus_stop();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b0, b[i]);
            applyStimulus(1'b1, b[i]);
            applyStimulus(1'b0, b[i]);
        end
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        a = sda_in;
        applyStimulus(1'b0, 1'b1);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, 1'b1);
            d[i] = sda_in;
            applyStimulus(1'b0, 1'b1);
        end
        applyStimulus(1'b0, nack);
        applyStimulus(1'b1, nack);
        applyStimulus(1'b0, nack);
        applyStimulus(1'b0, 1'b1);
    endtask

    // Directed test sequence
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        wr_total     = 0;
        oe_cycles    = 0;
        rst     = 1'b1;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("rst_regs_q", regs_q, 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        checkOutput("rst_wr_idx", 32'(wr_idx), 32'd0);

        // Auto-increment wrap: ptr=3, write 0x11, 0x22
        wr_base = wr_total;
        bus_start();
        write_byte(8'h54, ack);
        checkOutput("wrap_addr_ack", 32'(ack), 32'd0);
        checkOutput("wrap_busy", 32'(busy), 32'd1);
        write_byte(8'h03, ack);
        checkOutput("wrap_ptr_ack", 32'(ack), 32'd0);
        write_byte(8'h11, ack);
        checkOutput("wrap_d0_ack", 32'(ack), 32'd0);
        write_byte(8'h22, ack);
        checkOutput("wrap_d1_ack", 32'(ack), 32'd0);
        bus_stop();
        checkOutput("wrap_regs", regs_q, 32'h11000022);
        checkOutput("wrap_pulses", 32'(wr_total - wr_base), 32'd2);
        checkOutput("wrap_idx0", 32'(idx_log[wr_base]), 32'd3);
        checkOutput("wrap_idx1", 32'(idx_log[wr_base + 1]), 32'd0);
        checkOutput("wrap_busy_end", 32'(busy), 32'd0);

        // Plain write: reg1 = 0x55
        wr_base = wr_total;
        bus_start();
        write_byte(8'h54, ack);
        checkOutput("wr_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h01, ack);
        checkOutput("wr_ptr_ack", 32'(ack), 32'd0);
        write_byte(8'h55, ack);
        checkOutput("wr_data_ack", 32'(ack), 32'd0);
        checkOutput("wr_busy_mid", 32'(busy), 32'd1);
        bus_stop();
        checkOutput("wr_regs", regs_q, 32'h11005522);
        checkOutput("wr_pulses", 32'(wr_total - wr_base), 32'd1);
        checkOutput("wr_idx", 32'(idx_log[wr_base]), 32'd1);
        checkOutput("wr_busy_end", 32'(busy), 32'd0);

        // Read with repeated start from ptr=1: 0x55, then reg2=0x00
        bus_start();
        write_byte(8'h54, ack);
        write_byte(8'h01, ack);
        bus_start();
        write_byte(8'h55, ack);
        checkOutput("rd_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b0, rdata);
        checkOutput("rd_byte0", 32'(rdata), 32'h55);
        read_byte(1'b1, rdata);
        checkOutput("rd_byte1", 32'(rdata), 32'h00);
        bus_stop();
        checkOutput("rd_busy_end", 32'(busy), 32'd0);

        // Read without pointer set: ptr left at 3 returns 0x11
        bus_start();
        write_byte(8'h55, ack);
        read_byte(1'b1, rdata);
        checkOutput("rd_ptr3", 32'(rdata), 32'h11);
        bus_stop();

        // Address mismatch: target stays silent
        oe_base = oe_cycles;
        bus_start();
        write_byte(8'hAA, ack);
        checkOutput("nm_addr_nack", 32'(ack), 32'd1);
        checkOutput("nm_busy", 32'(busy), 32'd0);
        write_byte(8'hAA, ack);
        checkOutput("nm_data_nack", 32'(ack), 32'd1);
        bus_stop();
        checkOutput("nm_oe_cycles", 32'(oe_cycles - oe_base), 32'd0);
        checkOutput("nm_regs", regs_q, 32'h11005522);

        // Pointer-only write to 2, then read reg2, reg3
        wr_base = wr_total;
        bus_start();
        write_byte(8'h54, ack);
        write_byte(8'h02, ack);
        checkOutput("po_ptr_ack", 32'(ack), 32'd0);
        bus_stop();
        checkOutput("po_no_pulse", 32'(wr_total - wr_base), 32'd0);
        bus_start();
        write_byte(8'h55, ack);
        read_byte(1'b0, rdata);
        checkOutput("po_rd_reg2", 32'(rdata), 32'h00);
        read_byte(1'b1, rdata);
        checkOutput("po_rd_reg3", 32'(rdata), 32'h11);
        bus_stop();
        checkOutput("po_regs", regs_q, 32'h11005522);

        // Reset while driving MSB of reg0 (0x22, MSB=0)
        bus_start();
        write_byte(8'h55, ack);
        @(negedge clk);
        checkOutput("rr_driving", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rr_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("rr_regs", regs_q, 32'h0);
        checkOutput("rr_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);

        // Full write after reset: reg2 = 0xA5
        wr_base = wr_total;
        bus_start();
        write_byte(8'h54, ack);
        checkOutput("ar_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h02, ack);
        write_byte(8'hA5, ack);
        checkOutput("ar_data_ack", 32'(ack), 32'd0);
        bus_stop();
        checkOutput("ar_regs", regs_q, 32'h00A50000);
        checkOutput("ar_pulses", 32'(wr_total - wr_base), 32'd1);
        checkOutput("ar_idx", 32'(idx_log[wr_base]), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (slave) that sits on the bus downstream of the I2C controller and answers its transactions.
- Holds NREGS 8-bit registers behind a register pointer, supporting standard write, pointer-set and read sequences with auto-increment.
- Serves as the on-chip bus partner for controller bring-up, giving ACK/NACK and read-data paths to exercise.
- Fully synchronous to the system clock; SCL/SDA are oversampled, not used as clocks.

Parameters:
- TARGET_ADDR, 7'h2A, 7-bit bus address this target ACKs.
- NREGS, 4, number of registers; must be a power of two, 2..16.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronisers.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- scl_in  in  1  bus SCL level (already resolved, pulled-up).
- sda_in  in  1  bus SDA level (wired-AND of all drivers).
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- regs_q  out  8*NREGS  register contents, reg i at [8i+7:8i].
- wr_pulse  out  1  one-cycle strobe when a data byte is committed.
- wr_idx  out  log2(NREGS)  register index written, valid with wr_pulse.
- busy  out  1  high from an address-matched START until STOP or return to IDLE.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values: sda_oe=0, regs_q=0, wr_pulse=0, wr_idx=0, busy=0, ptr=0, state=IDLE. Reset mid-transaction aborts immediately and releases SDA.
- Inputs pass through SYNC_STAGES flops plus one history flop. Edge flags: scl_rise, scl_fall, start (SDA 1->0 while SCL=1), stop (SDA 0->1 while SCL=1).
- Data is sampled on scl_rise. sda_oe changes only on the cycle after scl_fall. Minimum SCL high/low time is SYNC_STAGES+3 clk.
- States and transitions:
  - IDLE: on start -> ADDR.
  - ADDR: shift 8 bits (7-bit address, then R/W). On the 8th scl_fall:
    - If the address matches, assert sda_oe, set busy=1 and go to ADDR_ACK.
    - Otherwise go to IGNORE with sda_oe=0.
  - ADDR_ACK: on the next scl_fall, release SDA. Then:
    - If R/W=0 -> WR_BYTE, with first_byte=1.
    - If R/W=1 -> RD_BYTE, drive MSB of regs[ptr] immediately (sda_oe = ~bit).
  - WR_BYTE: shift 8 bits. On the 8th scl_fall, assert ACK and go to WR_ACK.
    - If first_byte: ptr <= byte[log2(NREGS)-1:0], and first_byte clears.
    - Otherwise: regs[ptr] <= byte, wr_pulse=1, wr_idx=ptr, ptr <= ptr+1 (wraps mod NREGS).
  - WR_ACK: on scl_fall, release SDA and return to WR_BYTE.
  - RD_BYTE: shift out regs[ptr] MSB first, updating the next bit on each scl_fall. After the 8th bit, release SDA, set ptr <= ptr+1 (wraps) and go to RD_ACK.
  - RD_ACK: sample the controller's ACK on scl_rise.
    - SDA=0 (ACK) -> RD_BYTE with the next byte.
    - SDA=1 (NACK) -> IGNORE.
  - IGNORE: SDA released, wait for start or stop.
- Global transitions, overriding all states:
  - stop -> IDLE, busy=0, sda_oe=0.
  - start (including repeated start) -> ADDR, sda_oe=0, ptr retained.
  - If start and an edge event occur in the same cycle, start wins.
- Write with only the pointer byte then STOP: ptr updated, no register written, no wr_pulse.
- ptr persists across transactions; it resets only on rst.
- Bit counter is 3 bits wide. Byte completion is detected at count 7 on scl_fall.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE);
  - the R/W bit constants I2C_WRITE=0 and I2C_READ=1.
- Sub-module i2c_bus_sync: synchronisers plus scl_rise/scl_fall/start/stop detection. It is reused by the controller.

Test Plan:
- Write: START, 0x54 (0x2A+W), 0x01, 0x55, STOP -> ACK on all three bytes; regs[1]=0x55; one wr_pulse with wr_idx=1; busy falls after STOP.
- Read with repeated start: START, 0x54, 0x01, Sr, 0x55 (0x2A+R), controller ACKs byte 1 and NACKs byte 2, STOP -> bytes returned are 0x55 then regs[2]=0x00; ptr ends at 3.
- Address mismatch: START, 0xAA (0x55+W), 0xAA, STOP -> sda_oe stays 0 throughout; busy=0; regs unchanged.
- Auto-increment wrap: START, 0x54, 0x03, 0x11, 0x22, STOP -> regs[3]=0x11, regs[0]=0x22; wr_idx sequence 3, 0.
- Reset mid-read: assert rst while the target drives a 0 bit in RD_BYTE -> next cycle sda_oe=0, regs_q=0, busy=0; a following full write transaction succeeds.
- Pointer-only write: START, 0x54, 0x02, STOP, then a read transaction -> no wr_pulse; the read returns regs[2].
